// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: state encoding, rest code and the
// 12-entry base period table (C..B) at counter_width = 8.
package note_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] NOTE_REST = 4'd0;

    localparam logic [7:0] BASE_C  = 8'd239;
    localparam logic [7:0] BASE_CS = 8'd226;
    localparam logic [7:0] BASE_D  = 8'd213;
    localparam logic [7:0] BASE_DS = 8'd201;
    localparam logic [7:0] BASE_E  = 8'd190;
    localparam logic [7:0] BASE_F  = 8'd179;
    localparam logic [7:0] BASE_FS = 8'd169;
    localparam logic [7:0] BASE_G  = 8'd159;
    localparam logic [7:0] BASE_GS = 8'd150;
    localparam logic [7:0] BASE_A  = 8'd142;
    localparam logic [7:0] BASE_AS = 8'd134;
    localparam logic [7:0] BASE_B  = 8'd127;

    // Rest and reserved codes map to a zero period.
    function automatic logic [7:0] base_period(input logic [3:0] code);
        case (code)
            4'd1:    base_period = BASE_C;
            4'd2:    base_period = BASE_CS;
            4'd3:    base_period = BASE_D;
            4'd4:    base_period = BASE_DS;
            4'd5:    base_period = BASE_E;
            4'd6:    base_period = BASE_F;
            4'd7:    base_period = BASE_FS;
            4'd8:    base_period = BASE_G;
            4'd9:    base_period = BASE_GS;
            4'd10:   base_period = BASE_A;
            4'd11:   base_period = BASE_AS;
            4'd12:   base_period = BASE_B;
            default: base_period = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational map of (note_code, note_octave) to a generator period and a
// pitched flag; the base table is scaled up to counter_width before shifting.
module note_period_lut
    import note_sequencer_pkg::*;
#(
    parameter int counter_width = 8
) (
    input  logic [3:0]               note_code,
    input  logic [1:0]               note_octave,
    output logic [counter_width-1:0] period,
    output logic                     pitched
);

    logic [counter_width-1:0] scaled;

    always_comb begin
        pitched = (note_code != NOTE_REST) && (note_code <= 4'd12);
        scaled  = counter_width'(base_period(note_code)) << (counter_width - 8);
        period  = pitched ? (scaled >> note_octave) : '0;
    end

endmodule

// File: rtl/note_sequencer.sv
// Note command sequencer feeding the square wave generator: holds each note for
// note_duration tempo ticks. Define NOTE_SEQ_GAP_EN for a silent inter-note gap.
//
// state | meaning
// IDLE  | ready for a command (unless stop); outputs held, gate low
// PLAY  | note sounding; prescaler and duration counter running
// GAP   | silent gap after a completed note (NOTE_SEQ_GAP_EN only)
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int counter_width  = 8,
    parameter int duration_width = 16,
    parameter int TICK_DIV       = 1000,
    parameter int GAP_CYCLES     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      note_valid,
    output logic                      note_ready,
    input  logic [3:0]                note_code,
    input  logic [1:0]                note_octave,
    input  logic [duration_width-1:0] note_duration,
    input  logic                      stop,
    output logic [counter_width-1:0]  frequency_control,
    output logic                      gate,
    output logic                      done,
    output logic                      busy
);

    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t                    state, state_next;
    logic [PRE_W-1:0]          pre, pre_next;
    logic [duration_width-1:0] dur_cnt, dur_next;
    logic [counter_width-1:0]  freq_next;
    logic                      gate_next, done_next;
    logic [counter_width-1:0]  lut_period;
    logic                      lut_pitched;

`ifdef NOTE_SEQ_GAP_EN
    localparam int              GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0]            gap_cnt, gap_next;
`endif

    note_period_lut #(.counter_width(counter_width)) u_lut (
        .note_code  (note_code),
        .note_octave(note_octave),
        .period     (lut_period),
        .pitched    (lut_pitched)
    );

    assign note_ready = !reset && (state == IDLE) && !stop;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            pre               <= '0;
            dur_cnt           <= '0;
            frequency_control <= '0;
            gate              <= 1'b0;
            done              <= 1'b0;
`ifdef NOTE_SEQ_GAP_EN
            gap_cnt           <= '0;
`endif
        end else begin
            state             <= state_next;
            pre               <= pre_next;
            dur_cnt           <= dur_next;
            frequency_control <= freq_next;
            gate              <= gate_next;
            done              <= done_next;
`ifdef NOTE_SEQ_GAP_EN
            gap_cnt           <= gap_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        pre_next   = pre;
        dur_next   = dur_cnt;
        freq_next  = frequency_control;
        gate_next  = gate;
        done_next  = 1'b0;
`ifdef NOTE_SEQ_GAP_EN
        gap_next   = gap_cnt;
`endif
        case (state)
            IDLE: begin
                gate_next = 1'b0;
                if (note_valid && note_ready) begin
                    freq_next = lut_period;
                    dur_next  = note_duration;
                    pre_next  = '0;
                    // A zero-length note completes immediately without leaving IDLE.
                    if (note_duration == '0) begin
                        done_next = 1'b1;
                    end else begin
                        gate_next  = lut_pitched;
                        state_next = PLAY;
                    end
                end
            end
            PLAY: begin
                if (stop) begin
                    gate_next  = 1'b0;
                    state_next = IDLE;
                end else if (pre == PRE_LAST) begin
                    pre_next = '0;
                    if (dur_cnt != '0) dur_next = dur_cnt - 1'b1;
                    if (dur_cnt == duration_width'(1)) begin
                        gate_next = 1'b0;
                        done_next = 1'b1;
`ifdef NOTE_SEQ_GAP_EN
                        gap_next   = GAP_LOAD;
                        state_next = GAP;
`else
                        state_next = IDLE;
`endif
                    end
                end else begin
                    pre_next = pre + 1'b1;
                end
            end
`ifdef NOTE_SEQ_GAP_EN
            GAP: begin
                gate_next = 1'b0;
                if (stop || gap_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt - 1'b1;
                end
            end
`endif
            default: begin
                gate_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer at TICK_DIV=4, counter_width=8; the gap
// scenario runs when NOTE_SEQ_GAP_EN is defined.
module tb_note_sequencer;

    localparam int CW = 8;
    localparam int DW = 16;
    localparam int TD = 4;
    localparam int GC = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          note_valid;
    logic          note_ready;
    logic [3:0]    note_code;
    logic [1:0]    note_octave;
    logic [DW-1:0] note_duration;
    logic          stop;
    logic [CW-1:0] frequency_control;
    logic          gate;
    logic          done;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    note_sequencer #(
        .counter_width (CW),
        .duration_width(DW),
        .TICK_DIV      (TD),
        .GAP_CYCLES    (GC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .note_valid       (note_valid),
        .note_ready       (note_ready),
        .note_code        (note_code),
        .note_octave      (note_octave),
        .note_duration    (note_duration),
        .stop             (stop),
        .frequency_control(frequency_control),
        .gate             (gate),
        .done             (done),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one edge (E0); returns sampled just after E0.
    task automatic send(input logic [3:0] code, input logic [1:0] oct, input logic [DW-1:0] dur);
        note_code     = code;
        note_octave   = oct;
        note_duration = dur;
        note_valid    = 1'b1;
        step();
        note_valid    = 1'b0;
    endtask

    // From the sample after E0: cycles until done, gate-high cycles before it, pulse width.
    task automatic watch(input string tag, input int exp_k, input int exp_gate);
        int k    = -1;
        int gcnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                k = i;
                break;
            end
            gcnt += int'(gate);
            step();
        end
        check({tag, " done_at"}, k, exp_k);
        check({tag, " gate_cycles"}, gcnt, exp_gate);
        check({tag, " gate_at_done"}, gate, 1'b0);
        step();
        check({tag, " done_width"}, done, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        note_valid    = 1'b1;
        note_code     = 4'd10;
        note_octave   = 2'd1;
        note_duration = 16'd3;
        stop          = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            check("rst ready", note_ready, 1'b0);
            check("rst gate", gate, 1'b0);
            check("rst freq", frequency_control, 8'd0);
        end
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        reset      = 1'b0;
        note_valid = 1'b0;
        #1;
        check("post_rst ready", note_ready, 1'b1);

`ifdef NOTE_SEQ_GAP_EN
        begin
            int k;
            int gap_len;
            int bad;
            send(4'd1, 2'd0, 16'd1);
            k = -1;
            for (int i = 0; i < 50; i++) begin
                if (done) begin k = i; break; end
                step();
            end
            check("gap done_at", k, 4);
            gap_len = 0;
            bad     = 0;
            for (int i = 0; i < 100; i++) begin
                if (!busy) break;
                gap_len++;
                if (gate || note_ready) bad++;
                step();
            end
            check("gap length", gap_len, GC);
            check("gap silent_not_ready", bad, 0);
            check("gap end ready", note_ready, 1'b1);

            send(4'd2, 2'd0, 16'd1);
            check("gap2 freq", frequency_control, 8'd226);
            k = -1;
            for (int i = 0; i < 50; i++) begin
                if (done) begin k = i; break; end
                step();
            end
            check("gap2 done_at", k, 4);
            step();
            step();
            stop = 1'b1;
            step();
            check("gap stop busy", busy, 1'b0);
            check("gap stop done", done, 1'b0);
            check("gap stop ready_blocked", note_ready, 1'b0);
            stop = 1'b0;
            #1;
            check("gap stop ready", note_ready, 1'b1);
        end
`else
        // Pitched A, one octave up: 142 >> 1.
        send(4'd10, 2'd1, 16'd3);
        check("a freq", frequency_control, 8'd71);
        check("a gate", gate, 1'b1);
        check("a busy", busy, 1'b1);
        check("a ready", note_ready, 1'b0);
        watch("a", 12, 12);
        check("a busy_after", busy, 1'b0);
        check("a freq_hold", frequency_control, 8'd71);

        send(4'd0, 2'd0, 16'd2);
        check("rest freq", frequency_control, 8'd0);
        watch("rest", 8, 0);
        send(4'd14, 2'd2, 16'd2);
        check("rsv freq", frequency_control, 8'd0);
        watch("rsv", 8, 0);

        send(4'd1, 2'd0, 16'd0);
        check("d0 freq", frequency_control, 8'd239);
        check("d0 ready", note_ready, 1'b1);
        check("d0 busy", busy, 1'b0);
        watch("d0", 0, 0);

        send(4'd5, 2'd0, 16'd4);
        check("stop freq", frequency_control, 8'd190);
        repeat (4) step();
        check("stop gate_before", gate, 1'b1);
        stop = 1'b1;
        step();
        check("stop gate", gate, 1'b0);
        check("stop busy", busy, 1'b0);
        check("stop done", done, 1'b0);
        check("stop ready_blocked", note_ready, 1'b0);
        stop = 1'b0;
        send(4'd3, 2'd0, 16'd1);
        check("after_stop busy", busy, 1'b1);
        check("after_stop freq", frequency_control, 8'd213);
        watch("after_stop", 4, 4);

        stop          = 1'b1;
        note_code     = 4'd2;
        note_duration = 16'd2;
        note_valid    = 1'b1;
        step();
        check("idle_stop busy", busy, 1'b0);
        check("idle_stop freq", frequency_control, 8'd213);
        stop       = 1'b0;
        note_valid = 1'b0;

        send(4'd7, 2'd0, 16'd1);
        repeat (3) step();
        stop = 1'b1;
        step();
        check("final_stop done", done, 1'b0);
        check("final_stop gate", gate, 1'b0);
        check("final_stop busy", busy, 1'b0);
        stop = 1'b0;
        step();
        check("final_stop done_late", done, 1'b0);

        // B three octaves up: 127 >> 3.
        send(4'd12, 2'd3, 16'd5);
        check("mid freq", frequency_control, 8'd15);
        step();
        step();
        reset = 1'b1;
        step();
        check("mid_rst freq", frequency_control, 8'd0);
        check("mid_rst gate", gate, 1'b0);
        check("mid_rst busy", busy, 1'b0);
        check("mid_rst ready", note_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst ready_after", note_ready, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
